// File: rtl/filtro_debounce.sv
// Debounce filter with edge pulses for an already-synchronized input.
// Optional FILTRO_GLITCH_CNT_EN adds a saturating count of aborted confirmations.
//
//   state      | meaning
//   S_LOW      | accepted level 0, input agrees
//   S_CHK_HIGH | accepted level 0, counting consecutive 1 samples
//   S_HIGH     | accepted level 1, input agrees
//   S_CHK_LOW  | accepted level 1, counting consecutive 0 samples
module filtro_debounce #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       signal_in,
    output logic       signal_out,
    output logic       rise_pulse,
    output logic       fall_pulse
`ifdef FILTRO_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (signal_in) begin
                    state_d = S_CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_CHK_HIGH: begin
                if (!signal_in) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!signal_in) begin
                    state_d = S_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_CHK_LOW: begin
                if (signal_in) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    assign signal_out = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef FILTRO_GLITCH_CNT_EN
    logic       glitch_ev;
    logic [7:0] glitch_q;

    // A glitch is a confirmation aborted by the input returning to the accepted level.
    assign glitch_ev = ((state_q == S_CHK_HIGH) && !signal_in) ||
                       ((state_q == S_CHK_LOW)  &&  signal_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= 8'h00;
        end else if (glitch_ev && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'h01;
        end
    end

    assign glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_filtro_debounce.sv
// Scoreboard bench for filtro_debounce with STABLE_CYCLES=4; the reference model
// tracks the accepted level and the run length of samples disagreeing with it.
module tb_filtro_debounce;

    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signal_in = 1'b0;
    logic signal_out, rise_pulse, fall_pulse;
`ifdef FILTRO_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    always #5 clk = ~clk;

    filtro_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef FILTRO_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

    typedef struct packed {
        logic       out;
        logic       rise;
        logic       fall;
        logic [7:0] glitch;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: level is the accepted value, run counts consecutive
    // samples that disagree with it; STABLE of them in a row flip the level.
    logic m_level = 1'b0;
    int   m_run   = 0;
    int   m_glitch = 0;

    always @(posedge clk) begin
        exp_t e;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (rst) begin
            m_level  = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else if (signal_in != m_level) begin
            m_run = m_run + 1;
            if (m_run == STABLE) begin
                m_level = signal_in;
                m_run   = 0;
                if (signal_in) e.rise = 1'b1;
                else           e.fall = 1'b1;
            end
        end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch = m_glitch + 1;
            m_run = 0;
        end
        e.out    = m_level;
        e.glitch = 8'(m_glitch);
        exp_q.push_back(e);
    end

    task automatic cmp(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, got, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard cycle %0d: got empty queue want entry", cyc);
        end else begin
            e = exp_q.pop_front();
            cmp("signal_out", int'(signal_out), int'(e.out));
            cmp("rise_pulse", int'(rise_pulse), int'(e.rise));
            cmp("fall_pulse", int'(fall_pulse), int'(e.fall));
`ifdef FILTRO_GLITCH_CNT_EN
            cmp("glitch_count", int'(glitch_count), int'(e.glitch));
`endif
        end
    end

    task automatic step(input logic r, input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = r;
            signal_in = s;
        end
    endtask

    initial begin
        int v, len;
        // reset held with input high, then a clean rise
        step(1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 6);
        // from high: a 3-sample dip is rejected, then a clean 4-sample fall
        step(1'b0, 1'b0, 3);
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 6);
        // from low: a 3-sample high is rejected
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 3);
        // toggling every cycle drives the glitch counter into saturation
        for (int i = 0; i < 600; i++) step(1'b0, 1'(i % 2 == 0), 1);
        step(1'b0, 1'b0, 3);
        // reset in the middle of a high confirmation discards progress
        step(1'b0, 1'b1, 2);
        step(1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 3);
        // randomized runs with occasional reset
        for (int i = 0; i < 250; i++) begin
            v   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 6));
            if ($urandom_range(0, 39) == 0) step(1'b1, 1'(v), 1);
            step(1'b0, 1'(v), len);
        end
        step(1'b0, 1'b0, 8);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
